// File: rtl/pipe_flow_ctrl_pkg.sv
// Shared MIPS decode constants and the fetch/decode flow-controller state encoding.
// Imported by the flow controller, its hazard detector and any reuse site.
package mips_pkg;

  localparam logic [5:0]  OP_LW    = 6'h23;
  localparam logic [5:0]  OP_J     = 6'h02;
  localparam logic [5:0]  OP_JAL   = 6'h03;
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_BNE   = 6'h05;
  localparam logic [5:0]  FUNCT_JR = 6'h08;

  // add $zero,$zero,$zero: architecturally inert, used as the ID bubble
  localparam logic [31:0] NOP_WORD = 32'h0000_0020;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } flow_state_t;

  function automatic logic [5:0] opcode(input logic [31:0] w);
    return w[31:26];
  endfunction

endpackage

// File: rtl/pipe_flow_ctrl_if.sv
// Fetch/decode flow-control bundle: EX/memory controls in, PC and IF/ID register out.
// master = flow controller, slave = surrounding pipeline / environment.
interface pipe_flow_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      if_instr;
  logic             ex_redirect;
  logic [31:0]      ex_target;
  logic             mem_stall;
  logic [31:0]      pc;
  logic [31:0]      id_instr;
  logic [31:0]      id_pc4;
  logic             id_valid;
  logic [CNT_W-1:0] bubble_cnt;
  logic [1:0]       state;

  modport master (
    input  if_instr, ex_redirect, ex_target, mem_stall,
    output pc, id_instr, id_pc4, id_valid, bubble_cnt, state
  );

  modport slave (
    output if_instr, ex_redirect, ex_target, mem_stall,
    input  pc, id_instr, id_pc4, id_valid, bubble_cnt, state
  );
endinterface

// File: rtl/pipe_flow_ctrl_hazard_detect.sv
// Load-use detector: flags an lw in ID whose rt is read by the instruction being fetched.
// Latency: combinational; backpressure: none, the result feeds the stall decision directly.
module hazard_detect
  import mips_pkg::*;
(
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic [31:0] if_instr,
  output logic        lu
);

  logic [4:0] id_rt;
  logic [4:0] if_rs;
  logic [4:0] if_rt;
  logic       unused_fields;

  assign id_rt = id_instr[20:16];
  assign if_rs = if_instr[25:21];
  assign if_rt = if_instr[20:16];

  // rs and rt are both compared whatever the format of the fetched word
  assign lu = id_valid && (opcode(id_instr) == OP_LW) && (id_rt != 5'd0) &&
              ((id_rt == if_rs) || (id_rt == if_rt));

  assign unused_fields = ^{id_instr[25:21], id_instr[15:0], if_instr[31:26], if_instr[15:0]};

endmodule

// File: rtl/pipe_flow_ctrl.sv
// PC + IF/ID register sequencer for load-use stalls, ID jumps and EX redirects.
// Latency: 1 cycle per decision, one bubble per hazard; backpressure: mem_stall freezes all state.
module pipe_flow_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_flow_ctrl_if.master bus
);

  logic [31:0]      pc_q;
  logic [31:0]      id_instr_q;
  logic [31:0]      id_pc4_q;
  logic             id_valid_q;
  logic [CNT_W-1:0] cnt_q;
  flow_state_t      state_q;

  logic             lu;
  logic             is_jump;
  logic [31:0]      pc_plus4;
  logic [31:0]      jump_target;
  logic [CNT_W-1:0] cnt_sat;

  hazard_detect u_hazard_detect (
    .id_instr (id_instr_q),
    .id_valid (id_valid_q),
    .if_instr (bus.if_instr),
    .lu       (lu)
  );

  assign is_jump     = id_valid_q &&
                       ((opcode(id_instr_q) == OP_J) || (opcode(id_instr_q) == OP_JAL));
  assign pc_plus4    = pc_q + 32'd4;
  assign jump_target = {id_pc4_q[31:28], id_instr_q[25:0], 2'b00};
  assign cnt_sat     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // id_pc4 is left untouched on bubbles; consumers qualify it with id_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      id_instr_q <= NOP_WORD;
      id_pc4_q   <= 32'd0;
      id_valid_q <= 1'b0;
      cnt_q      <= '0;
      state_q    <= RUN;
    end else if (!bus.mem_stall) begin
      if (bus.ex_redirect) begin
        pc_q       <= bus.ex_target;
        id_instr_q <= NOP_WORD;
        id_valid_q <= 1'b0;
        cnt_q      <= cnt_sat;
        state_q    <= FLUSH;
      end else if (lu) begin
        id_instr_q <= NOP_WORD;
        id_valid_q <= 1'b0;
        cnt_q      <= cnt_sat;
        state_q    <= LU_STALL;
      end else if (is_jump) begin
        pc_q       <= jump_target;
        id_instr_q <= NOP_WORD;
        id_valid_q <= 1'b0;
        cnt_q      <= cnt_sat;
        state_q    <= FLUSH;
      end else begin
        pc_q       <= pc_plus4;
        id_instr_q <= bus.if_instr;
        id_pc4_q   <= pc_plus4;
        id_valid_q <= 1'b1;
        state_q    <= RUN;
      end
    end
  end

  assign bus.pc         = pc_q;
  assign bus.id_instr   = id_instr_q;
  assign bus.id_pc4     = id_pc4_q;
  assign bus.id_valid   = id_valid_q;
  assign bus.bubble_cnt = cnt_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed scoreboard bench for pipe_flow_ctrl (CNT_W=4 build so saturation is reachable).
module tb_pipe_flow_ctrl;
  import mips_pkg::*;

  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0020;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [1:0]  state;
    logic [3:0]  cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];
  logic [3:0] exp_cnt;

  pipe_flow_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_flow_ctrl #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: the IF/ID register updates every edge, so an observation exists every cycle
  initial begin : monitor
    exp_t m;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        m = sb.pop_front();
        chk(m.name, "pc",         bus.pc,                 m.pc);
        chk(m.name, "id_instr",   bus.id_instr,           m.id_instr);
        chk(m.name, "id_pc4",     bus.id_pc4,             m.id_pc4);
        chk(m.name, "id_valid",   {31'd0, bus.id_valid},  {31'd0, m.id_valid});
        chk(m.name, "state",      {30'd0, bus.state},     {30'd0, m.state});
        chk(m.name, "bubble_cnt", {28'd0, bus.bubble_cnt}, {28'd0, m.cnt});
      end
    end
  end

  task automatic step(input string nm, input logic [31:0] ifw, input logic rd, input logic [31:0] tgt,
                      input logic ms, input logic bub, input logic [31:0] e_pc, input logic [31:0] e_id,
                      input logic [31:0] e_pc4, input logic e_vld, input logic [1:0] e_st);
    exp_t e;
    bus.if_instr    = ifw;
    bus.ex_redirect = rd;
    bus.ex_target   = tgt;
    bus.mem_stall   = ms;
    if (bub && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    e.name = nm; e.pc = e_pc; e.id_instr = e_id; e.id_pc4 = e_pc4;
    e.id_valid = e_vld; e.state = e_st; e.cnt = exp_cnt;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 4'd0;
    rst_n    = 1'b0;

    step("reset", 32'h20010005, 0, 0, 0, 0, 32'h0, NOP, 32'h0, 0, RUN);
    rst_n = 1'b1;

    // straight-line fetch
    step("seq0", 32'h20010005, 0, 0, 0, 0, 32'h4, 32'h20010005, 32'h4, 1, RUN);
    step("seq1", 32'h20010005, 0, 0, 0, 0, 32'h8, 32'h20010005, 32'h8, 1, RUN);
    // lw $1 then add $2,$1,$1: one bubble, add refetched
    step("lw1",  32'h8C010000, 0, 0, 0, 0, 32'hC, 32'h8C010000, 32'hC, 1, RUN);
    step("lu1",  32'h00211020, 0, 0, 0, 1, 32'hC, NOP, 32'hC, 0, LU_STALL);
    step("lu1r", 32'h00211020, 0, 0, 0, 0, 32'h10, 32'h00211020, 32'h10, 1, RUN);
    // lw $1 then $3/$4 user: no stall
    step("lw1b", 32'h8C010000, 0, 0, 0, 0, 32'h14, 32'h8C010000, 32'h14, 1, RUN);
    step("nolu", 32'h00642820, 0, 0, 0, 0, 32'h18, 32'h00642820, 32'h18, 1, RUN);
    // lw $0 then $0 user: no stall
    step("lw0",  32'h8C000000, 0, 0, 0, 0, 32'h1C, 32'h8C000000, 32'h1C, 1, RUN);
    step("nolu0",32'h00001020, 0, 0, 0, 0, 32'h20, 32'h00001020, 32'h20, 1, RUN);
    // lw $4 then sw $4: rt-rt match still stalls
    step("lw4",  32'h8C040000, 0, 0, 0, 0, 32'h24, 32'h8C040000, 32'h24, 1, RUN);
    step("lurt", 32'hAC640000, 0, 0, 0, 1, 32'h24, NOP, 32'h24, 0, LU_STALL);
    step("lurtr",32'hAC640000, 0, 0, 0, 0, 32'h28, 32'hAC640000, 32'h28, 1, RUN);
    // redirect into upper region, then j 0x40 from id_pc4=0x10000008
    step("redir",32'h20010005, 1, 32'h10000004, 0, 1, 32'h10000004, NOP, 32'h28, 0, FLUSH);
    step("jfet", 32'h08000040, 0, 0, 0, 0, 32'h10000008, 32'h08000040, 32'h10000008, 1, RUN);
    step("jmp",  32'h20010005, 0, 0, 0, 1, 32'h10000100, NOP, 32'h10000008, 0, FLUSH);
    // jal in ID loses to an EX redirect
    step("jalf", 32'h0C000080, 0, 0, 0, 0, 32'h10000104, 32'h0C000080, 32'h10000104, 1, RUN);
    step("rdwin",32'h20010005, 1, 32'h200, 0, 1, 32'h200, NOP, 32'h10000104, 0, FLUSH);
    // mem_stall across a pending load-use (and a redirect) freezes everything
    step("lw1c", 32'h8C010000, 0, 0, 0, 0, 32'h204, 32'h8C010000, 32'h204, 1, RUN);
    step("ms0",  32'h00211020, 1, 32'h300, 1, 0, 32'h204, 32'h8C010000, 32'h204, 1, RUN);
    step("ms1",  32'h00211020, 0, 0, 1, 0, 32'h204, 32'h8C010000, 32'h204, 1, RUN);
    step("ms2",  32'h00211020, 0, 0, 1, 0, 32'h204, 32'h8C010000, 32'h204, 1, RUN);
    step("msrel",32'h00211020, 0, 0, 0, 1, 32'h204, NOP, 32'h204, 0, LU_STALL);
    step("msfin",32'h00211020, 0, 0, 0, 0, 32'h208, 32'h00211020, 32'h208, 1, RUN);
    // pc+4 wraps to zero
    step("wrapr",32'h20010005, 1, 32'hFFFFFFFC, 0, 1, 32'hFFFFFFFC, NOP, 32'h208, 0, FLUSH);
    step("wrap", 32'h20010005, 0, 0, 0, 0, 32'h0, 32'h20010005, 32'h0, 1, RUN);
    // drive the 4-bit bubble counter past all-ones
    for (int i = 0; i < 10; i++)
      step("sat", 32'h20010005, 1, 32'h40, 0, 1, 32'h40, NOP, 32'h0, 0, FLUSH);
    step("satrun",32'h20010005, 0, 0, 0, 0, 32'h44, 32'h20010005, 32'h44, 1, RUN);

    // short reset pulse between edges must still clear state
    rst_n = 1'b0;
    #1;
    rst_n   = 1'b1;
    exp_cnt = 4'd0;
    step("arst", 32'h20010005, 0, 0, 0, 0, 32'h4, 32'h20010005, 32'h4, 1, RUN);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
